// File: rtl/bitonic_sorter_pkg.sv
// ----------------------------------------------------------------------------
// bitonic_sorter_pkg
//   Shared types for the muon sorter slice.
//   muon_t     : one candidate, {pt, roi}. pt is the sort key; roi rides along.
//   id_t       : requester index for the default requester count.
//   muon_set_t : one full candidate set for the default set width.
//   out_of_order(a, b, ascending) : 1 when a must move behind b.
// ----------------------------------------------------------------------------
package bitonic_sorter_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_NREQ  = 4;
    localparam int PT_W      = 4;
    localparam int ROI_W     = 4;

    typedef struct packed {
        logic [PT_W-1:0]  pt;
        logic [ROI_W-1:0] roi;
    } muon_t;

    typedef logic [$clog2(DEF_NREQ)-1:0] id_t;
    typedef muon_t muon_set_t [0:DEF_WIDTH-1];

    function automatic logic out_of_order(input muon_t a, input muon_t b, input logic ascending);
        return ascending ? (a.pt > b.pt) : (a.pt < b.pt);
    endfunction

endpackage

// File: rtl/retiming_bitonic.sv
// ----------------------------------------------------------------------------
// retiming_bitonic
//   Combinational bitonic network followed by DELAY register stages that
//   synthesis is free to retime into the network. No stall, no reset: the
//   data is qualified externally by a parallel valid/tag pipeline.
//   DIR=1 sorts descending by pt (index 0 holds the largest), DIR=0 ascending.
// Ports:
//   clk : clock
//   d   : WIDTH candidates in
//   q   : WIDTH candidates sorted, DELAY cycles after d
// ----------------------------------------------------------------------------
module retiming_bitonic
    import bitonic_sorter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter bit DIR   = 1'b1,
    parameter int DELAY = 2
) (
    input  logic  clk,
    input  muon_t d [0:WIDTH-1],
    output muon_t q [0:WIDTH-1]
);

    muon_t net [0:WIDTH-1];

    // Classic in-place bitonic schedule: block size k doubles, compare
    // distance j halves. A block sorts "up" when bit k of the lane index is 0;
    // XOR with DIR flips the whole network for a descending result.
    always_comb begin
        muon_t tmp;
        int    l;
        logic  asc;
        net = d;
        tmp = '0;
        l   = 0;
        asc = 1'b0;
        for (int k = 2; k <= WIDTH; k = k * 2) begin
            for (int j = k / 2; j > 0; j = j / 2) begin
                for (int i = 0; i < WIDTH; i++) begin
                    l   = i ^ j;
                    asc = (((i & k) == 0) != DIR);
                    if (l > i && out_of_order(net[i], net[l], asc)) begin
                        tmp    = net[i];
                        net[i] = net[l];
                        net[l] = tmp;
                    end
                end
            end
        end
    end

    if (DELAY == 0) begin : g_comb
        assign q = net;
    end else begin : g_pipe
        muon_t stg [0:DELAY-1][0:WIDTH-1];
        always_ff @(posedge clk) begin
            stg[0] <= net;
            for (int s = 1; s < DELAY; s++) begin
                stg[s] <= stg[s-1];
            end
        end
        assign q = stg[DELAY-1];
    end

endmodule

// File: rtl/sort_share_arbiter_rr.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//   Round-robin arbiter. Scans req cyclically from the pointer and picks the
//   first set bit. grant is one-hot only when en is high; the pointer moves
//   to the slot after the winner only on an actual grant.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset (pointer -> 0)
//   req        : request vector
//   en         : allow a grant this cycle
//   grant      : one-hot grant (zero when !en or no request)
//   grant_idx  : index of the candidate winner (valid when grant_any)
//   grant_any  : some request is pending, independent of en
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            grant_any
);

    logic [IDW-1:0] ptr;

    always_comb begin
        int c;
        c         = 0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int off = 0; off < NREQ; off++) begin
            c = int'(ptr) + off;
            if (c >= NREQ) c = c - NREQ;
            if (!grant_any && req[c]) begin
                grant_any = 1'b1;
                grant_idx = IDW'(c);
            end
        end
        grant = '0;
        if (en && grant_any) grant[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (en && grant_any) begin
            ptr <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/sort_share_arbiter.sv
// ----------------------------------------------------------------------------
// sort_share_arbiter
//   Shares one pipelined bitonic sorter between NREQ requesters. A round-robin
//   arbiter issues at most one set per cycle into an input register that feeds
//   retiming_bitonic; a {valid,id} tag pipeline runs alongside, and finished
//   sets land in an FWFT FIFO. An occupancy counter (in-flight + stored) gates
//   issue so the non-stallable sorter can never overrun the FIFO.
//
//   Handshakes: a transfer happens on a cycle where valid & ready are both 1.
//   Input side: req_ready is one-hot (or zero), combinational from req_valid,
//   hold and occupancy, and never depends on out_ready. Output side: out_q and
//   out_id hold still while out_valid & !out_ready.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset (drops everything in flight)
//   req_m      : candidate sets, one per requester
//   req_valid  : set available per requester
//   req_ready  : set accepted this cycle
//   hold       : block new grants; in-flight sets still drain
//   out_q      : sorted set at FIFO head
//   out_id     : requester index of out_q
//   out_valid  : FIFO head valid
//   out_ready  : pop head when out_valid & out_ready
//   busy       : occupancy counter non-zero
// ----------------------------------------------------------------------------
module sort_share_arbiter
    import bitonic_sorter_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int NREQ       = 4,
    parameter int DELAY      = 2,
    parameter int FIFO_DEPTH = 4,
    parameter bit DIR        = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  muon_t                   req_m [0:NREQ-1][0:WIDTH-1],
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic                    hold,
    output muon_t                   out_q [0:WIDTH-1],
    output logic [$clog2(NREQ)-1:0] out_id,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy
);

    localparam int IDW = $clog2(NREQ);
    localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = $clog2(FIFO_DEPTH + 1);

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            grant_any;
    logic [CW-1:0]   occ;
    logic            arb_en, issue, pop, fifo_wr;

    // No credit check against a same-cycle pop: keeps ready off out_ready.
    assign arb_en    = !hold && (occ < CW'(FIFO_DEPTH));
    assign issue     = arb_en && grant_any;
    assign req_ready = grant;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_valid),
        .en        (arb_en),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // Input register and tag pipeline. tag_*[0] is the input register's tag;
    // tag_*[DELAY] lines up with the sorter output.
    muon_t          in_data [0:WIDTH-1];
    muon_t          sort_q  [0:WIDTH-1];
    logic [DELAY:0] tag_vld;
    logic [IDW-1:0] tag_id  [0:DELAY];

    always_ff @(posedge clk) begin
        if (issue) in_data <= req_m[grant_idx];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_vld <= '0;
            for (int s = 0; s <= DELAY; s++) tag_id[s] <= '0;
        end else begin
            tag_vld[0] <= issue;
            tag_id[0]  <= grant_idx;
            for (int s = 1; s <= DELAY; s++) begin
                tag_vld[s] <= tag_vld[s-1];
                tag_id[s]  <= tag_id[s-1];
            end
        end
    end

    retiming_bitonic #(.WIDTH(WIDTH), .DIR(DIR), .DELAY(DELAY)) u_sort (
        .clk (clk),
        .d   (in_data),
        .q   (sort_q)
    );

    // Output FWFT FIFO.
    muon_t          mem    [0:FIFO_DEPTH-1][0:WIDTH-1];
    logic [IDW-1:0] mem_id [0:FIFO_DEPTH-1];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign fifo_wr   = tag_vld[DELAY];
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign out_q     = mem[rd_ptr];
    assign out_id    = mem_id[rd_ptr];
    assign busy      = (occ != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            occ    <= '0;
            for (int e = 0; e < FIFO_DEPTH; e++) begin
                mem_id[e] <= '0;
                for (int w = 0; w < WIDTH; w++) mem[e][w] <= '0;
            end
        end else begin
            if (fifo_wr) begin
                mem[wr_ptr]    <= sort_q;
                mem_id[wr_ptr] <= tag_id[DELAY];
                wr_ptr         <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({fifo_wr, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            case ({issue, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // Credit accounting guarantees a write never lands on a full FIFO.
    always_ff @(posedge clk) begin
        if (rst_n && fifo_wr) assert (count != CW'(FIFO_DEPTH));
    end

endmodule

// File: tb/tb_sort_share_arbiter.sv
module tb_sort_share_arbiter;
    import bitonic_sorter_pkg::*;

    localparam int WIDTH = 16;
    localparam int NREQ  = 4;
    localparam int DELAY = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // ---------------- DUT signals ----------------
    muon_t      req_m [0:NREQ-1][0:WIDTH-1];
    logic [3:0] req_valid, req_ready, req_valid1, req_ready1;
    logic       hold, hold1;
    muon_t      out_q [0:WIDTH-1], out_q1 [0:WIDTH-1];
    logic [1:0] out_id, out_id1;
    logic       out_valid, out_ready, busy, out_valid1, out_ready1, busy1;

    sort_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .DELAY(DELAY), .FIFO_DEPTH(4), .DIR(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .req_m(req_m), .req_valid(req_valid), .req_ready(req_ready),
        .hold(hold), .out_q(out_q), .out_id(out_id), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy)
    );

    sort_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .DELAY(DELAY), .FIFO_DEPTH(1), .DIR(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_m(req_m), .req_valid(req_valid1), .req_ready(req_ready1),
        .hold(hold1), .out_q(out_q1), .out_id(out_id1), .out_valid(out_valid1),
        .out_ready(out_ready1), .busy(busy1)
    );

    // ---------------- bookkeeping ----------------
    int n_assert = 0;
    int n_fail   = 0;
    int iss_cnt  = 0, pop_cnt  = 0;
    int iss1_cnt = 0, pop1_cnt = 0;
    logic [1:0] exp_q[$];
    logic [1:0] exp1_q[$];
    logic [3:0] pt_tab [0:NREQ-1][0:WIDTH-1];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [127:0] flat(input muon_t s [0:WIDTH-1]);
        logic [127:0] r;
        r = '0;
        for (int j = 0; j < WIDTH; j++) r[127-8*j -: 8] = s[j];
        return r;
    endfunction

    // Every set is a permutation of pt 0..15, so descending slot j holds pt 15-j.
    function automatic logic [127:0] exp_set(input int id);
        logic [127:0] r;
        r = '0;
        for (int j = 0; j < WIDTH; j++)
            for (int k = 0; k < WIDTH; k++)
                if (pt_tab[id][k] == 4'(15 - j)) r[127-8*j -: 8] = {pt_tab[id][k], 4'(k)};
        return r;
    endfunction

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        logic [1:0] e;
        if (!rst_n) begin
            exp_q.delete();
            exp1_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                pop_cnt++;
                n_assert++;
                assert (exp_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL unexpected_out observed_id=%0d expected=no output", out_id);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("out_id", 128'(out_id), 128'(e));
                    chk("out_q", flat(out_q), exp_set(int'(e)));
                end
            end
            if (out_valid1 && out_ready1) begin
                pop1_cnt++;
                n_assert++;
                assert (exp1_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL unexpected_out1 observed_id=%0d expected=no output", out_id1);
                end
                if (exp1_q.size() != 0) begin
                    e = exp1_q.pop_front();
                    chk("out_id1", 128'(out_id1), 128'(e));
                    chk("out_q1", flat(out_q1), exp_set(int'(e)));
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    exp_q.push_back(2'(i));
                    iss_cnt++;
                end
                if (req_valid1[i] && req_ready1[i]) begin
                    exp1_q.push_back(2'(i));
                    iss1_cnt++;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((busy || out_valid) && n < 100) begin
            tick();
            n++;
        end
        chk(tag, 128'({busy, out_valid}), 128'(0));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [63:0] t2;
        logic [3:0]  t2_exp [0:7];
        logic [3:0]  exp4;
        int          base_iss, base_pop;

        t2 = 64'h391E_70C5_A2F8_4B6D;
        for (int i = 0; i < NREQ; i++)
            for (int j = 0; j < WIDTH; j++)
                pt_tab[i][j] = 4'((j * 5 + i) % 16);
        for (int j = 0; j < WIDTH; j++) pt_tab[2][j] = t2[63-4*j -: 4];
        for (int i = 0; i < NREQ; i++)
            for (int j = 0; j < WIDTH; j++) begin
                req_m[i][j].pt  = pt_tab[i][j];
                req_m[i][j].roi = 4'(j);
            end

        rst_n = 1'b0; req_valid = '0; hold = 1'b0; out_ready = 1'b1;
        req_valid1 = '0; hold1 = 1'b0; out_ready1 = 1'b1;
        tick(); tick();

        // reset values
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_req_ready", 128'(req_ready), 128'(0));
        chk("rst_out_id", 128'(out_id), 128'(0));
        chk("rst_out_q", flat(out_q), 128'(0));
        chk("rst_busy1", 128'(busy1), 128'(0));
        rst_n = 1'b1;
        tick();

        // single requester 2, latency DELAY+2
        req_valid = 4'b0100; #1;
        chk("t1_ready", 128'(req_ready), 128'(4'b0100));
        tick(); req_valid = '0; #1;
        chk("t1_ov_c1", 128'(out_valid), 128'(0));
        tick(); tick(); #1;
        chk("t1_ov_c3", 128'(out_valid), 128'(0));
        tick(); #1;
        chk("t1_ov_c4", 128'(out_valid), 128'(1));
        chk("t1_id_c4", 128'(out_id), 128'(2));
        chk("t1_q_c4", flat(out_q), exp_set(2));
        tick(); #1;
        chk("t1_busy_c5", 128'(busy), 128'(0));
        chk("t1_ov_c5", 128'(out_valid), 128'(0));

        // reset puts the pointer back to 0; then all requesters valid
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        t2_exp[0] = 4'b0001; t2_exp[1] = 4'b0010; t2_exp[2] = 4'b0100; t2_exp[3] = 4'b1000;
        t2_exp[4] = 4'b0000; t2_exp[5] = 4'b0001; t2_exp[6] = 4'b0010; t2_exp[7] = 4'b0100;
        req_valid = 4'hf;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk("t2_grant", 128'(req_ready), 128'(t2_exp[c]));
            tick();
        end
        req_valid = '0;
        wait_drain("t2_drain");
        chk("t2_sb_empty", 128'(exp_q.size()), 128'(0));

        // backpressure: exactly FIFO_DEPTH issues, then stall; release and drain
        base_iss = iss_cnt; base_pop = pop_cnt;
        out_ready = 1'b0; req_valid = 4'hf;
        repeat (8) tick();
        #1;
        chk("t3_issues", 128'(iss_cnt - base_iss), 128'(4));
        chk("t3_ready_full", 128'(req_ready), 128'(0));
        chk("t3_out_valid", 128'(out_valid), 128'(1));
        out_ready = 1'b1;
        repeat (12) tick();
        req_valid = '0;
        wait_drain("t3_drain");
        chk("t3_balance", 128'(pop_cnt - base_pop), 128'(iss_cnt - base_iss));
        chk("t3_sb_empty", 128'(exp_q.size()), 128'(0));

        // hold after two issues
        base_iss = iss_cnt; base_pop = pop_cnt;
        req_valid = 4'hf;
        tick(); tick();
        hold = 1'b1; #1;
        chk("t5_issues", 128'(iss_cnt - base_iss), 128'(2));
        chk("t5_busy_c2", 128'(busy), 128'(1));
        for (int c = 2; c < 8; c++) begin
            #1;
            chk("t5_no_ready", 128'(req_ready), 128'(0));
            tick();
        end
        req_valid = '0; hold = 1'b0; #1;
        chk("t5_busy_c8", 128'(busy), 128'(0));
        chk("t5_pops", 128'(pop_cnt - base_pop), 128'(2));

        // reset with three sets in flight
        base_iss = iss_cnt;
        req_valid = 4'hf;
        tick(); tick(); tick();
        req_valid = '0; rst_n = 1'b0; #1;
        chk("t6_inflight", 128'(iss_cnt - base_iss), 128'(3));
        tick(); #1;
        chk("t6_ov_after_rst", 128'(out_valid), 128'(0));
        chk("t6_busy_after_rst", 128'(busy), 128'(0));
        base_pop = pop_cnt;
        rst_n = 1'b1; req_valid = 4'b1010; #1;
        chk("t6_first_grant", 128'(req_ready), 128'(4'b0010));
        tick(); req_valid = '0;
        wait_drain("t6_drain");
        chk("t6_pops", 128'(pop_cnt - base_pop), 128'(1));
        chk("t6_sb_empty", 128'(exp_q.size()), 128'(0));

        // depth-1 instance: credit-limited to one issue per DELAY+3 cycles
        req_valid1 = 4'hf;
        for (int c = 0; c < 20; c++) begin
            exp4 = (c % 5 == 0) ? (4'b0001 << (c / 5)) : 4'b0000;
            #1;
            chk("t4_grant", 128'(req_ready1), 128'(exp4));
            tick();
        end
        req_valid1 = '0;
        begin
            int n;
            n = 0;
            while ((busy1 || out_valid1) && n < 100) begin
                tick();
                n++;
            end
        end
        chk("t4_drain", 128'({busy1, out_valid1}), 128'(0));
        chk("t4_issues", 128'(iss1_cnt), 128'(4));
        chk("t4_pops", 128'(pop1_cnt), 128'(4));
        chk("t4_sb_empty", 128'(exp1_q.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
